// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the two-port memory arbiter:
//   state_t            arbiter FSM state encoding (IDLE / OWN0 / OWN1)
//   PORT0 / PORT1      port index constants used for winner and last-served
//   MAX_BURST_DEFAULT  default burst limit under contention
//   cntWidth()         width of a counter able to hold 0 .. maxBurst-1
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int MAX_BURST_DEFAULT = 4;

    function automatic int cntWidth(input int maxBurst);
        return (maxBurst > 1) ? $clog2(maxBurst) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Winner selection for the arbiter's IDLE state.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests go to the port that was not last served
//   undefined -> simultaneous requests always go to port 0
// Ports:
//   i_req0, i_req1  request lines of port 0 / port 1
//   i_last          last-served port index (PORT0 / PORT1)
//   o_win           selected port index; only meaningful when a request is up
// ---------------------------------------------------------------------------
module arb_pick
    import mc_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_win
);

`ifndef ARB_ROUND_ROBIN_EN
    // Last-served only matters for round-robin; keep it visibly consumed.
    logic w_unusedLast;
    assign w_unusedLast = i_last;
`endif

    always_comb begin
        o_win = PORT0;
        if (i_req0 && i_req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            o_win = (i_last == PORT0) ? PORT1 : PORT0;
`else
            o_win = PORT0;
`endif
        end else if (i_req1) begin
            o_win = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single-port memory with combinational read.
// Port 0 is the core, port 1 the loader/DMA. A port that owns the memory is
// served every cycle it requests; under contention ownership rotates after
// MAX_BURST grants.
// Configuration macro: ARB_ROUND_ROBIN_EN (see arb_pick).
// Ports:
//   clk, rst (async, active-low)
//   req0/1, we0/1, addr0/1, wdata0/1   per-port request (held until gnt)
//   gnt0/1                             access performed this cycle
//   rdata0/1, rvalid0/1                registered read data, one-cycle valid
//   mem_a, mem_wd, mem_we, mem_rd      shared memory interface
// ---------------------------------------------------------------------------
module mem_arbiter
    import mc_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    localparam int            CW        = cntWidth(MAX_BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nextCnt;
    logic          r_last;
    logic          w_nextLast;
    logic          w_win;

    arb_pick u_pick (
        .i_req0 (req0),
        .i_req1 (req1),
        .i_last (r_last),
        .o_win  (w_win)
    );

    // State register together with burst counter and last-served pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= PORT1;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_last  <= w_nextLast;
        end
    end

    // Next-state logic. In OWNX a high reqX is a grant, so reaching the last
    // beat with reqX high is the "limit reached on a grant" condition. When
    // the other port is idle the owner simply restarts its count and stays.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextLast  = r_last;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_nextState = (w_win == PORT1) ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!req0 || (r_cnt == LAST_BEAT)) begin
                    if (req1) begin
                        w_nextState = OWN1;
                    end else if (req0) begin
                        w_nextCnt = '0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            OWN1: begin
                if (!req1 || (r_cnt == LAST_BEAT)) begin
                    if (req0) begin
                        w_nextState = OWN0;
                    end else if (req1) begin
                        w_nextCnt = '0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_nextState != r_state) begin
            w_nextCnt = '0;
            if (w_nextState == OWN0) begin
                w_nextLast = PORT0;
            end else if (w_nextState == OWN1) begin
                w_nextLast = PORT1;
            end
        end
    end

    // Grants and memory mux; everything follows the state register, so an
    // asynchronous reset drops a write in flight immediately.
    always_comb begin
        gnt0   = (r_state == OWN0) && req0;
        gnt1   = (r_state == OWN1) && req1;
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        if (gnt0) begin
            mem_a  = addr0;
            mem_wd = wdata0;
            mem_we = we0;
        end else if (gnt1) begin
            mem_a  = addr1;
            mem_wd = wdata1;
            mem_we = we1;
        end
    end

    // Read return path: capture at the end of the grant cycle, valid next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            if (gnt0 && !we0) begin
                rdata0 <= mem_rd;
            end
            if (gnt1 && !we1) begin
                rdata1 <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (MAX_BURST=4, AW=DW=32) with a small
// behavioural memory. A directed vector table covers idle handoff, port-1
// write/read and simultaneous-request priority (expectation depends on
// ARB_ROUND_ROBIN_EN); hand-written sequences cover burst rotation,
// uncontended streaming and reset during a write.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [31:0] VAL_R = 32'hDEADBEEF;
    localparam logic [31:0] VAL_W = 32'h12345678;
    localparam logic [31:0] VAL_K = 32'h11112222;
    localparam logic [31:0] VAL_O = 32'hAAAA5555;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:255];

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic        req0;
        logic        we0;
        logic [7:0]  addr0;
        logic        req1;
        logic        we1;
        logic [7:0]  addr1;
        logic [31:0] wdata1;
        logic [4:0]  expCtl;
        logic [31:0] expRdata0;
        logic [31:0] expRdata1;
        logic [7:0]  expAddr;
    } vec_t;

    vec_t vecs [0:12];

    mem_arbiter #(.MAX_BURST(4), .AW(32), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the rising edge.
    assign mem_rd = mem[mem_a[7:0]];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = VAL_R;
        mem[8'h20] = VAL_K;
        mem[8'h40] = VAL_O;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_a[7:0]] <= mem_wd;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic r0, input logic w0, input logic [7:0] a0,
                                   input logic r1, input logic w1, input logic [7:0] a1,
                                   input logic [31:0] wd1, input logic [4:0] ctl,
                                   input logic [31:0] rd0, input logic [31:0] rd1,
                                   input logic [7:0] ea);
        vec_t v;
        v.req0 = r0; v.we0 = w0; v.addr0 = a0;
        v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = wd1;
        v.expCtl = ctl; v.expRdata0 = rd0; v.expRdata1 = rd1; v.expAddr = ea;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        req0   = v.req0;
        we0    = v.we0;
        addr0  = {24'h0, v.addr0};
        wdata0 = 32'h0;
        req1   = v.req1;
        we1    = v.we1;
        addr1  = {24'h0, v.addr1};
        wdata1 = v.wdata1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Hold reset with both requests up, check the reset values, and release
    // one time unit after a rising edge; the caller's next cycle is IDLE.
    task automatic resetDut(input string tag);
        rst  = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        checkOutput({tag, " rst ctl"}, {27'h0, gnt0, gnt1, rvalid0, rvalid1, mem_we}, 32'h0);
        checkOutput({tag, " rst rdata0"}, rdata0, 32'h0);
        checkOutput({tag, " rst rdata1"}, rdata1, 32'h0);
        checkOutput({tag, " rst mem_a"}, mem_a, 32'h0);
        @(posedge clk);
        #1;
        clearInputs();
        rst = 1'b1;
    endtask

    initial begin
        int   runLen;
        logic expG0, expG1;

        // ctl = {gnt0, gnt1, rvalid0, rvalid1, mem_we}
        vecs[0]  = mkVec(1, 0, 8'h10, 0, 0, 8'h00, 32'h0,  5'b00000, 32'h0, 32'h0, 8'h00);
        vecs[1]  = mkVec(1, 0, 8'h10, 0, 0, 8'h00, 32'h0,  5'b10000, 32'h0, 32'h0, 8'h10);
        vecs[2]  = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,  5'b00100, VAL_R, 32'h0, 8'h00);
        vecs[3]  = mkVec(0, 0, 8'h00, 1, 1, 8'h40, VAL_W,  5'b00000, VAL_R, 32'h0, 8'h00);
        vecs[4]  = mkVec(0, 0, 8'h00, 1, 1, 8'h40, VAL_W,  5'b01001, VAL_R, 32'h0, 8'h40);
        vecs[5]  = mkVec(0, 0, 8'h00, 1, 0, 8'h40, 32'h0,  5'b01000, VAL_R, 32'h0, 8'h40);
        vecs[6]  = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,  5'b00010, VAL_R, VAL_W, 8'h00);
        vecs[7]  = mkVec(1, 0, 8'h20, 0, 0, 8'h00, 32'h0,  5'b00000, VAL_R, VAL_W, 8'h00);
        vecs[8]  = mkVec(1, 0, 8'h20, 0, 0, 8'h00, 32'h0,  5'b10000, VAL_R, VAL_W, 8'h20);
        vecs[9]  = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,  5'b00100, VAL_K, VAL_W, 8'h00);
        vecs[10] = mkVec(1, 0, 8'h10, 1, 0, 8'h20, 32'h0,  5'b00000, VAL_K, VAL_W, 8'h00);
`ifdef ARB_ROUND_ROBIN_EN
        vecs[11] = mkVec(1, 0, 8'h10, 1, 0, 8'h20, 32'h0,  5'b01000, VAL_K, VAL_W, 8'h20);
        vecs[12] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,  5'b00010, VAL_K, VAL_K, 8'h00);
`else
        vecs[11] = mkVec(1, 0, 8'h10, 1, 0, 8'h20, 32'h0,  5'b10000, VAL_K, VAL_W, 8'h10);
        vecs[12] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 32'h0,  5'b00100, VAL_R, VAL_W, 8'h00);
`endif

        $display("[TB] starting");
        resetDut("init");

        // Directed vector table, one row per clock cycle.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d ctl", i), {27'h0, gnt0, gnt1, rvalid0, rvalid1, mem_we},
                        {27'h0, vecs[i].expCtl});
            checkOutput($sformatf("vec%0d rdata0", i), rdata0, vecs[i].expRdata0);
            checkOutput($sformatf("vec%0d rdata1", i), rdata1, vecs[i].expRdata1);
            checkOutput($sformatf("vec%0d mem_a", i), mem_a, {24'h0, vecs[i].expAddr});
            @(posedge clk);
            #1;
        end
        clearInputs();

        // Contention from reset release: port 0 first, then 4-grant rotation.
        resetDut("burst");
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        for (int c = 0; c < 20; c++) begin
            expG0 = (c >= 1) && ((((c - 1) / 4) % 2) == 0);
            expG1 = (c >= 1) && ((((c - 1) / 4) % 2) == 1);
            @(negedge clk);
            checkOutput($sformatf("burst c%0d gnt", c), {30'h0, gnt0, gnt1}, {30'h0, expG0, expG1});
            @(posedge clk);
            #1;
        end
        clearInputs();

        // Uncontended streaming: 10 request cycles give 9 back-to-back grants.
        resetDut("stream");
        runLen = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stream c%0d gnt", c), {30'h0, gnt0, gnt1},
                        {30'h0, (c >= 1) ? 1'b1 : 1'b0, 1'b0});
            if (gnt0) runLen++;
            @(posedge clk);
            #1;
        end
        clearInputs();
        checkOutput("stream grant count", runLen, 32'd9);

        // Reset asserted in the middle of a port-1 write grant cycle.
        resetDut("midwr");
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("midwr idle gnt1", {31'h0, gnt1}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midwr gnt1", {31'h0, gnt1}, 32'h1);
        checkOutput("midwr mem_we", {31'h0, mem_we}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midwr reset gnt1", {31'h0, gnt1}, 32'h0);
        checkOutput("midwr reset mem_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midwr memory kept", mem[8'h40], VAL_W);
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive granted accesses per port while the other port is requesting.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 req0 / req1  input  1  access request from port 0 (core) / port 1 (loader/DMA).
REQ-007 we0 / we1  input  1  1 = write, 0 = read, for the port's pending request.
REQ-008 addr0 / addr1  input  AW  byte address of the port's request.
REQ-009 wdata0 / wdata1  input  DW  write data of the port's request.
REQ-010 gnt0 / gnt1  output  1  the port's access is performed in this cycle.
REQ-011 rdata0 / rdata1  output  DW  registered read data for the port.
REQ-012 rvalid0 / rvalid1  output  1  rdataX is valid this cycle (one-cycle pulse).
REQ-013 mem_a  output  AW  address to the shared memory.
REQ-014 mem_wd  output  DW  write data to the shared memory.
REQ-015 mem_we  output  1  write enable to the shared memory.
REQ-016 mem_rd  input  DW  combinational read data from the shared memory.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1; the state register is the only grant source.
REQ-018 gntX SHALL be (state==OWNX) & reqX, combinational; at most one gnt high in any cycle.
REQ-019 With gntX high: mem_a=addrX, mem_wd=wdataX, mem_we=weX; with no grant: mem_a=0, mem_wd=0, mem_we=0.
REQ-020 Granted read in cycle N: rdataX <= mem_rd at the end of N; rvalidX high in cycle N+1 only; rdata of the other port unchanged.
REQ-021 Granted write: memory written at the edge ending the grant cycle; no rvalid pulse.
REQ-022 IDLE: if a single reqX is high, the next state is OWNX (first grant one cycle after the request); if both are high, the port selected by the arbitration policy (REQ-029/030) wins; if neither, stay in IDLE.
REQ-023 OWNX: burst counter increments on every gntX and is cleared on every state change.
REQ-024 OWNX exits when reqX is low or the counter reaches MAX_BURST-1 on a grant: other port requesting -> OWNY; else reqX high -> stay OWNX with counter cleared; else -> IDLE.
REQ-025 If the other port is not requesting, a port keeps ownership indefinitely; MAX_BURST applies only under contention.
REQ-026 Requesters SHALL hold req/we/addr/wdata stable until gnt; the arbiter does not buffer requests.
REQ-027 The last-served pointer updates to X on every transition into OWNX.

Reset
REQ-028 While rst=0, asynchronously: state=IDLE, counter=0, last-served=1, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, mem_we=0; a write in progress when reset asserts is dropped.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE grant the port that is not last-served.
REQ-030 Without ARB_ROUND_ROBIN_EN: simultaneous requests in IDLE always grant port 0; MAX_BURST rotation (REQ-024) remains in force.

Structure
REQ-031 The FSM state encoding, port index constants and the MAX_BURST default SHALL reside in the shared package mc_pkg.
REQ-032 The winner selection (two requests + last-served -> winner) SHALL be a sub-module named arb_pick.

Verification
REQ-033 Idle handoff: req0=1, we0=0, addr0=0x10, mem holds 0xDEADBEEF at 0x10 -> gnt0 in cycle 2, rvalid0 with rdata0=0xDEADBEEF in cycle 3.
REQ-034 Contention, ARB_ROUND_ROBIN_EN defined: req0 and req1 both high from reset release -> port 0 wins first, then ownership alternates every 4 grants (MAX_BURST=4).
REQ-035 Fixed priority (macro undefined): both requests high in IDLE -> gnt0 first; port 1 granted after 4 port-0 grants.
REQ-036 Write then read: port 1 writes 0x12345678 to 0x40, then reads 0x40 -> rdata1=0x12345678, rvalid0 never pulses.
REQ-037 Reset mid-write: rst driven low during a gnt1 write cycle -> mem_we=0 and gnt1=0 immediately; memory at the address keeps its old value.
REQ-038 Uncontended streaming: req0 held high for 10 cycles, req1 low -> 9 consecutive gnt0 cycles with no forced rotation.
